// File: rtl/kgp_pkg.sv
// kgp_pkg: shared types and constants for the KGP multi-cycle sequencer.
//   state_e   - sequencer states (encoding is visible on the debug port state_o)
//   opclass_e - instruction class produced by the opcode classifier
//   OP_*      - primary opcode values (instr[31:26])
//   ALUOP_*   - operation class codes sent to the ALU control unit
package kgp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_HALT    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } opclass_e;

    localparam logic [5:0] OP_ALU0   = 6'b000000;
    localparam logic [5:0] OP_ALU1   = 6'b000001;
    localparam logic [5:0] OP_ALU2   = 6'b000010;
    localparam logic [5:0] OP_ALU3   = 6'b000011;
    localparam logic [5:0] OP_ALU4   = 6'b000100;
    localparam logic [5:0] OP_LOAD   = 6'b000101;
    localparam logic [5:0] OP_STORE  = 6'b000110;
    localparam logic [5:0] OP_BRANCH = 6'b000111;
    localparam logic [5:0] OP_HALT   = 6'b001000;

    localparam logic [2:0] ALUOP_CLS0 = 3'b000;
    localparam logic [2:0] ALUOP_CLS1 = 3'b001;
    localparam logic [2:0] ALUOP_CLS2 = 3'b010;
    localparam logic [2:0] ALUOP_CLS5 = 3'b101;
    localparam logic [2:0] ALUOP_CLS6 = 3'b110;

    // Address computation for load/store reuses ALU class 101 with this funct.
    localparam logic [5:0] FUNCT_ADDR = 6'b000001;

endpackage

// File: rtl/kgp_opdecode.sv
// kgp_opdecode: combinational opcode classifier.
//   opcode_i    - primary opcode (instr[31:26])
//   aluop_o     - ALU operation class for this opcode (000 for non-ALU classes)
//   funct_ovr_o - 1: replace funct with FUNCT_ADDR (load/store address add)
//   class_o     - instruction class steering the sequencer
module kgp_opdecode
    import kgp_pkg::*;
(
    input  logic [5:0] opcode_i,
    output logic [2:0] aluop_o,
    output logic       funct_ovr_o,
    output opclass_e   class_o
);

    always_comb begin
        aluop_o     = ALUOP_CLS0;
        funct_ovr_o = 1'b0;
        class_o     = CLS_ILLEGAL;
        case (opcode_i)
            OP_ALU0:   begin aluop_o = ALUOP_CLS0; class_o = CLS_ALU; end
            OP_ALU1:   begin aluop_o = ALUOP_CLS1; class_o = CLS_ALU; end
            OP_ALU2:   begin aluop_o = ALUOP_CLS2; class_o = CLS_ALU; end
            OP_ALU3:   begin aluop_o = ALUOP_CLS5; class_o = CLS_ALU; end
            OP_ALU4:   begin aluop_o = ALUOP_CLS6; class_o = CLS_ALU; end
            OP_LOAD: begin
                aluop_o     = ALUOP_CLS5;
                funct_ovr_o = 1'b1;
                class_o     = CLS_LOAD;
            end
            OP_STORE: begin
                aluop_o     = ALUOP_CLS5;
                funct_ovr_o = 1'b1;
                class_o     = CLS_STORE;
            end
            OP_BRANCH: class_o = CLS_BRANCH;
            OP_HALT:   class_o = CLS_HALT;
            default:   class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/kgp_mc_sequencer.sv
// kgp_mc_sequencer: multi-cycle instruction sequencer
// (IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, terminal HALT).
//   clk, rst         - clock; asynchronous active-high reset
//   start            - leave IDLE and begin fetching
//   instr            - instruction bus, latched on the FETCH ack cycle
//   mem_ack          - completion of the current memory request
//   mem_req/mem_we   - memory request / write qualifier
//   addr_sel         - 0 = PC, 1 = ALU result
//   ir_load, pc_inc, pc_branch, alu_en, reg_write - one-cycle strobes
//   aluop, alu_funct - registered ALU control, updated in DECODE
//   state_o          - current state (debug)
//   halted, fault    - sticky status
module kgp_mc_sequencer
    import kgp_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        pc_branch,
    output logic        alu_en,
    output logic        reg_write,
    output logic [2:0]  aluop,
    output logic [5:0]  alu_funct,
    output logic [2:0]  state_o,
    output logic        halted,
    output logic        fault
);

    localparam int unsigned       WAIT_W   = $clog2(MEM_WAIT_MAX + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_WAIT_MAX);

    state_e            state_q, state_d;
    opclass_e          class_q, class_d;
    logic [5:0]        ir_op_q, ir_op_d;
    logic [5:0]        ir_fn_q, ir_fn_d;
    logic [2:0]        aluop_q, aluop_d;
    logic [5:0]        funct_q, funct_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic              waiting;
    logic              wait_hit;

    logic [2:0]        dec_aluop;
    logic              dec_ovr;
    opclass_e          dec_class;

    // Only opcode and funct are kept from the instruction word.
    logic              unused_instr_bits;
    assign unused_instr_bits = ^instr[25:6];

    kgp_opdecode u_opdecode (
        .opcode_i    (ir_op_q),
        .aluop_o     (dec_aluop),
        .funct_ovr_o (dec_ovr),
        .class_o     (dec_class)
    );

    // Saturating wait count; the timeout fires in the cycle whose count
    // would reach MEM_WAIT_MAX, so exactly MEM_WAIT_MAX wait cycles elapse.
    assign waiting  = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ack;
    assign wait_inc = (wait_q >= WAIT_LIM) ? wait_q : wait_q + WAIT_W'(1);
    assign wait_hit = (wait_inc >= WAIT_LIM);

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        ir_op_d   = ir_op_q;
        ir_fn_d   = ir_fn_q;
        aluop_d   = aluop_q;
        funct_d   = funct_q;
        fault_d   = fault_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_branch = 1'b0;
        alu_en    = 1'b0;
        reg_write = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    ir_op_d = instr[31:26];
                    ir_fn_d = instr[5:0];
                    state_d = ST_DECODE;
                end else if (wait_hit) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_DECODE: begin
                aluop_d = dec_aluop;
                funct_d = dec_ovr ? FUNCT_ADDR : ir_fn_q;
                class_d = dec_class;
                case (dec_class)
                    CLS_ALU, CLS_LOAD, CLS_STORE: state_d = ST_EXEC;
                    CLS_BRANCH: begin
                        pc_branch = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    CLS_HALT: state_d = ST_HALT;
                    default: begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end
                endcase
            end
            ST_EXEC: begin
                alu_en  = 1'b1;
                state_d = ((class_q == CLS_LOAD) || (class_q == CLS_STORE)) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (class_q == CLS_STORE);
                if (mem_ack) begin
                    state_d = (class_q == CLS_LOAD) ? ST_WB : ST_FETCH;
                end else if (wait_hit) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        halted_d = halted_q || (state_d == ST_HALT);

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (waiting) begin
            wait_d = wait_inc;
        end else begin
            wait_d = wait_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            class_q  <= CLS_ALU;
            ir_op_q  <= '0;
            ir_fn_q  <= '0;
            aluop_q  <= '0;
            funct_q  <= '0;
            wait_q   <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            class_q  <= class_d;
            ir_op_q  <= ir_op_d;
            ir_fn_q  <= ir_fn_d;
            aluop_q  <= aluop_d;
            funct_q  <= funct_d;
            wait_q   <= wait_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign aluop     = aluop_q;
    assign alu_funct = funct_q;
    assign state_o   = state_q;
    assign halted    = halted_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_kgp_mc_sequencer.sv
// Randomized self-checking bench for kgp_mc_sequencer. A transaction-level
// model expands each instruction (opcode, ack delays) into the expected
// per-cycle outputs, and the bench replays that list against the DUT.
module tb_kgp_mc_sequencer;

    localparam int unsigned MAXW = 15;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    logic        clk, rst, start, mem_ack;
    logic [31:0] instr;
    logic        mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_branch, alu_en, reg_write;
    logic [2:0]  aluop, state_o;
    logic [5:0]  alu_funct;
    logic        halted, fault;

    kgp_mc_sequencer #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .instr     (instr),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_branch (pc_branch),
        .alu_en    (alu_en),
        .reg_write (reg_write),
        .aluop     (aluop),
        .alu_funct (alu_funct),
        .state_o   (state_o),
        .halted    (halted),
        .fault     (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [2:0]  st;
        logic        req, we, asel, irl, pci, pcb, alu, rw, hlt, flt;
        logic        ack, start;
        logic [31:0] ins;
        logic        chk_alu;
        logic [2:0]  aop;
        logic [5:0]  afn;
    } step_t;

    step_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Model-side view of the registered ALU control and sticky status.
    logic       m_known;
    logic [2:0] m_aop;
    logic [5:0] m_afn;
    logic       m_halted, m_fault;

    logic [12:0] act_ctrl;
    assign act_ctrl = {state_o, mem_req, mem_we, addr_sel, ir_load, pc_inc,
                       pc_branch, alu_en, reg_write, halted, fault};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic step_t base(input logic [2:0] st);
        step_t s;
        s         = '0;
        s.st      = st;
        s.ack     = 1'($urandom);
        s.start   = 1'($urandom);
        s.ins     = $urandom;
        s.chk_alu = m_known;
        s.aop     = m_aop;
        s.afn     = m_afn;
        s.hlt     = m_halted;
        s.flt     = m_fault;
        return s;
    endfunction

    function automatic logic [12:0] exp_ctrl(input step_t s);
        return {s.st, s.req, s.we, s.asel, s.irl, s.pci, s.pcb, s.alu, s.rw, s.hlt, s.flt};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [5:0] op;
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r <= 7)       op = 6'(r);
        else if (r <= 13) op = 6'($urandom_range(0, 7));
        else if (r == 14) op = 6'd8;
        else              op = 6'($urandom_range(9, 63));
        return {op, 20'($urandom), 6'($urandom)};
    endfunction

    function automatic int unsigned rand_delay();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r < 10)      return $urandom_range(0, 3);
        else if (r < 14) return $urandom_range(4, MAXW - 1);
        else             return MAXW + 2;
    endfunction

    // Expand one instruction into expected cycles.
    task automatic plan_instr(input logic [31:0] w, input int unsigned d1,
                              input int unsigned d2, output bit done);
        step_t      s;
        logic [5:0] op, fn;
        op   = w[31:26];
        fn   = w[5:0];
        done = 1'b0;

        for (int unsigned k = 0; k < d1 && k < MAXW; k++) begin
            s = base(S_FETCH); s.req = 1'b1; s.ack = 1'b0; s.ins = w;
            exp_q.push_back(s);
        end
        if (d1 >= MAXW) begin
            m_halted = 1'b1; m_fault = 1'b1; done = 1'b1;
            return;
        end
        s = base(S_FETCH); s.req = 1'b1; s.ack = 1'b1; s.irl = 1'b1; s.pci = 1'b1; s.ins = w;
        exp_q.push_back(s);

        s = base(S_DECODE); s.pcb = (op == 6'd7);
        exp_q.push_back(s);

        if (op <= 6'd4) begin
            case (op)
                6'd0:    m_aop = 3'b000;
                6'd1:    m_aop = 3'b001;
                6'd2:    m_aop = 3'b010;
                6'd3:    m_aop = 3'b101;
                default: m_aop = 3'b110;
            endcase
            m_afn = fn; m_known = 1'b1;
            s = base(S_EXEC); s.alu = 1'b1; exp_q.push_back(s);
            s = base(S_WB);   s.rw  = 1'b1; exp_q.push_back(s);
        end else if (op == 6'd5 || op == 6'd6) begin
            m_aop = 3'b101; m_afn = 6'b000001; m_known = 1'b1;
            s = base(S_EXEC); s.alu = 1'b1; exp_q.push_back(s);
            for (int unsigned k = 0; k < d2 && k < MAXW; k++) begin
                s = base(S_MEM); s.req = 1'b1; s.asel = 1'b1; s.we = (op == 6'd6); s.ack = 1'b0;
                exp_q.push_back(s);
            end
            if (d2 >= MAXW) begin
                m_halted = 1'b1; m_fault = 1'b1; done = 1'b1;
                return;
            end
            s = base(S_MEM); s.req = 1'b1; s.asel = 1'b1; s.we = (op == 6'd6); s.ack = 1'b1;
            exp_q.push_back(s);
            if (op == 6'd5) begin
                s = base(S_WB); s.rw = 1'b1; exp_q.push_back(s);
            end
        end else if (op == 6'd7) begin
            m_known = 1'b0;
        end else if (op == 6'd8) begin
            m_known = 1'b0; m_halted = 1'b1; done = 1'b1;
        end else begin
            m_known = 1'b0; m_halted = 1'b1; m_fault = 1'b1; done = 1'b1;
        end
    endtask

    task automatic run_steps(input int max_n);
        step_t s;
        int    n;
        n = 0;
        while (exp_q.size() > 0 && n < max_n) begin
            s = exp_q.pop_front();
            @(negedge clk);
            start   = s.start;
            mem_ack = s.ack;
            instr   = s.ins;
            #1;
            check_eq("ctrl", 32'(act_ctrl), 32'(exp_ctrl(s)));
            if (s.chk_alu) check_eq("aluctl", 32'({aluop, alu_funct}), 32'({s.aop, s.afn}));
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst     = 1'b1;
        start   = 1'($urandom);
        mem_ack = 1'($urandom);
        #1;
        check_eq("rst_ctrl", 32'(act_ctrl), 32'd0);
        check_eq("rst_alu", 32'({aluop, alu_funct}), 32'd0);
        start = 1'b0;
        #1 rst = 1'b0;
        m_known = 1'b1; m_aop = '0; m_afn = '0; m_halted = 1'b0; m_fault = 1'b0;
    endtask

    initial begin
        step_t       s;
        bit          done;
        logic [31:0] w;
        int unsigned d1, d2;

        rst = 1'b1; start = 1'b0; mem_ack = 1'b0; instr = '0;
        m_known = 1'b1; m_aop = '0; m_afn = '0; m_halted = 1'b0; m_fault = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int sc = 0; sc < 24; sc++) begin
            do_reset();
            repeat ($urandom_range(0, 2)) begin
                s = base(S_IDLE); s.start = 1'b0; exp_q.push_back(s);
            end
            s = base(S_IDLE); s.start = 1'b1; exp_q.push_back(s);
            done = 1'b0;
            for (int i = 0; i < 6 && !done; i++) begin
                w  = rand_word();
                d1 = rand_delay();
                d2 = rand_delay();
                if (i == 0) begin
                    case (sc)
                        0: begin w = 32'h0000_0001; d1 = 0; end
                        1: begin w = {6'd0, 26'($urandom)}; d1 = MAXW + 3; end
                        2: begin w = {6'd5, 26'($urandom)}; d1 = 2; d2 = 2; end
                        3: begin w = {6'd6, 26'($urandom)}; d1 = 0; d2 = 1; end
                        4: begin w = {6'h3f, 26'($urandom)}; d1 = 0; end
                        default: ;
                    endcase
                end
                plan_instr(w, d1, d2, done);
                run_steps(1000);
            end
            if (done) begin
                repeat (4) exp_q.push_back(base(S_HALT));
                run_steps(1000);
            end
        end

        // Reset in the middle of a load's MEM wait, then stray acks.
        do_reset();
        s = base(S_IDLE); s.start = 1'b1; exp_q.push_back(s);
        plan_instr({6'd5, 26'h0}, 0, 10, done);
        run_steps(6);
        check_eq("pre_rst_mem", 32'(state_o), 32'(S_MEM));
        #1 rst = 1'b1;
        #1;
        check_eq("rst_mid_mem", 32'(act_ctrl), 32'd0);
        exp_q.delete();
        start   = 1'b0;
        mem_ack = 1'b1;
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            start   = 1'b0;
            mem_ack = 1'b1;
            #1;
            check_eq("stray_ack", 32'(act_ctrl), 32'd0);
            check_eq("stray_alu", 32'({aluop, alu_funct}), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/kgp_mc_sequencer.md
KGP_MC_SEQUENCER -- requirements
Module: kgp_mc_sequencer

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15: memory-ack cycles tolerated before timeout.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset; asynchronous, active-high.
REQ-004 SHALL have port start, input, 1: leave IDLE and begin fetching.
REQ-005 SHALL have port instr, input, 32: instruction bus; opcode = instr[31:26], funct = instr[5:0].
REQ-006 SHALL have port mem_ack, input, 1: memory completion for the current mem_req.
REQ-007 SHALL have port mem_req, output, 1: memory access request.
REQ-008 SHALL have port mem_we, output, 1: write when mem_req is high.
REQ-009 SHALL have port addr_sel, output, 1: memory address select; 0 = PC, 1 = ALU result.
REQ-010 SHALL have outputs ir_load, pc_inc, pc_branch, alu_en and reg_write, each output, 1, one-cycle strobes.
REQ-011 SHALL have port aluop, output, 3: operation class sent to the ALU control unit.
REQ-012 SHALL have port alu_funct, output, 6: funct sent to the ALU control unit.
REQ-013 SHALL have port state_o, output, 3: current state for debug.
REQ-014 SHALL have outputs halted and fault, each output, 1: sticky status.

Function
REQ-015 SHALL implement the states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-016 IDLE SHALL move to FETCH when start=1; otherwise it SHALL hold.
REQ-017 FETCH SHALL hold mem_req=1 and addr_sel=0; in the mem_ack cycle it SHALL pulse ir_load and pc_inc, latch instr and go to DECODE.
REQ-018 DECODE SHALL take 1 cycle and classify the latched opcode:
- 000000 -> aluop 000, funct passed through
- 000001 -> aluop 001, funct passed through
- 000010 -> aluop 010, funct passed through
- 000011 -> aluop 101, funct passed through
- 000100 -> aluop 110, funct passed through
- 000101 (load) and 000110 (store) -> aluop 101, alu_funct 000001
- 000111 -> branch
- 001000 -> halt
REQ-019 Any other opcode SHALL set fault=1 and go to HALT.
REQ-020 For opcodes 000000-000100, EXEC SHALL pulse alu_en for 1 cycle, then go to WB.
REQ-021 For load and store, EXEC SHALL pulse alu_en, then go to MEM.
REQ-022 For branch, DECODE SHALL pulse pc_branch, then go to FETCH; EXEC SHALL NOT be entered.
REQ-023 For halt, DECODE SHALL go to HALT.
REQ-024 MEM SHALL hold mem_req=1 and addr_sel=1, with mem_we=1 for store only.
REQ-025 On mem_ack in MEM, a load SHALL go to WB and a store SHALL go to FETCH.
REQ-026 WB SHALL pulse reg_write for 1 cycle, then go to FETCH.
REQ-027 mem_req SHALL stay asserted and stable until mem_ack, then deassert in the following cycle.
REQ-028 mem_ack outside FETCH or MEM SHALL be ignored.
REQ-029 A wait counter SHALL count cycles in FETCH and MEM with mem_ack=0.
REQ-030 When the wait count reaches MEM_WAIT_MAX, the block SHALL set fault=1 and go to HALT.
REQ-031 The wait counter SHALL clear on every state change.
REQ-032 The wait counter SHALL saturate and SHALL NOT wrap.
REQ-033 HALT SHALL be terminal: halted=1, all strobes 0, start ignored; only rst exits it.
REQ-034 aluop and alu_funct SHALL be registered in DECODE and held until the next DECODE.
REQ-035 Latency: an R-type instruction SHALL take FETCH(1 + wait) + DECODE + EXEC + WB = 4 cycles at zero wait.
REQ-036 Latency: a load SHALL take 5 cycles plus both memory waits.

Reset
REQ-037 rst=1 SHALL force state IDLE asynchronously, with all outputs 0, aluop 000, alu_funct 000000, wait counter 0, halted=0 and fault=0.
REQ-038 Reset mid-access SHALL drop mem_req immediately; the outstanding ack SHALL be ignored.

Structure
REQ-039 A shared package kgp_pkg SHALL hold the state enum, opcode constants and aluop class constants.
REQ-040 The opcode classifier SHALL be one combinational sub-module, kgp_opdecode: opcode -> {aluop, funct_override, class}.

Verification
REQ-041 Reset, start=1, instr=0x00000001 with ack on the first FETCH cycle -> FETCH, DECODE, EXEC, WB; aluop=000, alu_funct=000001, reg_write at cycle 4.
REQ-042 Load opcode 000101 with 2-cycle ack delays -> mem_req held for 3 cycles each access; addr_sel=1 in MEM; aluop=101, alu_funct=000001; reg_write once.
REQ-043 Store opcode 000110 -> mem_we=1 only in MEM; no reg_write; returns to FETCH.
REQ-044 Opcode 111111 -> fault=1, halted=1 at the cycle after DECODE; strobes remain 0 with start toggling.
REQ-045 mem_ack never asserted in FETCH with MEM_WAIT_MAX=15 -> HALT with fault=1 after exactly 15 wait cycles.
REQ-046 rst asserted during MEM -> mem_req low in the same cycle; state IDLE; a later stray mem_ack has no effect.
